// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared flag struct and address-width helper for sync_fifo_ctrl
package fifo_pkg;

  // Registered status flags, updated together with the pointers
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Entry index width for a power-of-two depth
  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W storage, sync read (async read under SYNC_FIFO_FWFT_EN)
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rst;
  assign unused_rst = rst;

  // Fall-through read: head word shown while rd_en (non-empty), zero otherwise
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      rd_data = mem[rd_addr];
    end
  end
`else
  // Registered read: output register loads only on an accepted pop, holds otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO controller; SYNC_FIFO_FWFT_EN selects fall-through read
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 4,
  localparam int ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = PTR_W'(AF_LVL);
  localparam logic [ADDR_W:0] AE_CNT   = PTR_W'(AE_LVL);

  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [ADDR_W:0] count_q, count_nxt;
  fifo_flags_t     flags_q, flags_nxt;
  logic            ovf_q, udf_q, ovf_nxt, udf_nxt;
  logic            wr_ok, rd_ok, ram_rd_en;

  // Accept decisions from pre-edge flags, then next pointers, occupancy, flags and sticky errors
  always_comb begin
    wr_ok      = en & wr_en & ~flags_q.full;
    rd_ok      = en & rd_en & ~flags_q.empty;
    wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, wr_ok};
    rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_ok};
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    flags_nxt.full         = (count_nxt == FULL_CNT);
    flags_nxt.empty        = (count_nxt == '0);
    flags_nxt.almost_full  = (count_nxt >= AF_CNT);
    flags_nxt.almost_empty = (count_nxt <= AE_CNT);

    ovf_nxt = ovf_q;
    udf_nxt = udf_q;
    if (en) begin
      if (clr_err) begin
        ovf_nxt = 1'b0;
        udf_nxt = 1'b0;
      end
      if (wr_en && flags_q.full) begin
        ovf_nxt = 1'b1;
      end
      if (rd_en && flags_q.empty) begin
        udf_nxt = 1'b1;
      end
    end
  end

  // Pointer, occupancy, flag and error registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      flags_q <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      flags_q <= flags_nxt;
      ovf_q   <= ovf_nxt;
      udf_q   <= udf_nxt;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign ram_rd_en  = ~flags_q.empty;
  assign dout_valid = ~flags_q.empty;
`else
  logic dv_q;
  assign ram_rd_en  = rd_ok;
  assign dout_valid = dv_q;

  // Valid pulses for exactly the cycle after an accepted pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_q <= 1'b0;
    end else begin
      dv_q <= rd_ok;
    end
  end
`endif

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (din),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (dout)
  );

  assign count        = count_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - vector table, corner sequences and random queue-model check of sync_fifo_ctrl
module tb_sync_fifo_ctrl;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  int errors = 0;
  int checks = 0;

  sync_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: a plain queue plus sticky bits
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0, m_udf = 1'b0, m_dv = 1'b0;
  logic [DW-1:0] m_dout = '0;

  function automatic void model_edge();
    bit was_full, was_empty;
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0; m_dv = 1'b0;
    end else if (!en) begin
      m_dv = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_dv = rd_en && !was_empty;
      if (rd_en && !was_empty) m_dout = mq.pop_front();
      if (wr_en && !was_full) mq.push_back(din);
      if (clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (wr_en && was_full) m_ovf = 1'b1;
      if (rd_en && was_empty) m_udf = 1'b1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit e, input bit w, input bit rd, input bit c, input logic [DW-1:0] d);
    rst = r; en = e; wr_en = w; rd_en = rd; clr_err = c; din = d;
  endtask

  typedef struct {
    bit            rst, en, wr, rd, clr;
    logic [DW-1:0] din;
    int            cnt;
    bit            ovf, udf;
    logic [DW-1:0] dout;
    bit            dv;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit e, bit w, bit rd, bit c, int d, int cnt, bit o, bit u, int dt, bit v);
    vec_t x;
    x.rst = r; x.en = e; x.wr = w; x.rd = rd; x.clr = c; x.din = DW'(d);
    x.cnt = cnt; x.ovf = o; x.udf = u; x.dout = DW'(dt); x.dv = v;
    tbl.push_back(x);
  endfunction

  task automatic check_vs_model(input string tag);
    int n;
    logic [DW-1:0] ed;
    bit ev;
    n = mq.size();
`ifdef SYNC_FIFO_FWFT_EN
    ed = (n != 0) ? mq[0] : '0;
    ev = (n != 0);
`else
    ed = m_dout;
    ev = m_dv;
`endif
    chk({tag, ".count"}, int'(count), n);
    chk({tag, ".full"}, int'(full), int'(n == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".afull"}, int'(almost_full), int'(n >= AF));
    chk({tag, ".aempty"}, int'(almost_empty), int'(n <= AE));
    chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
    chk({tag, ".udf"}, int'(underflow), int'(m_udf));
    chk({tag, ".dout"}, int'(dout), int'(ed));
    chk({tag, ".dv"}, int'(dout_valid), int'(ev));
  endtask

  initial begin
    // Directed vectors: rst,en,wr,rd,clr,din -> count,ovf,udf,dout,dout_valid
    add(0,1,0,0,0,0, 0,0,0,0,0);
    for (int i = 1; i <= 8; i++) add(1,1,1,0,0,i, i,0,0,0,0);
    add(1,1,1,0,0,'hFF, 8,1,0,0,0);
    for (int i = 1; i <= 8; i++) add(1,1,0,1,0,0, 8-i,1,0,i,1);
    add(1,1,0,1,0,0, 0,1,1,8,0);
    add(1,1,0,0,1,0, 0,0,0,8,0);
    add(1,1,1,1,0,'h44, 1,0,1,8,0);
    add(1,1,0,1,1,0, 0,0,0,'h44,1);
    for (int i = 0; i < 5; i++) add(1,1,1,0,0,'h0A+i, i+1,0,0,'h44,0);
    for (int i = 0; i < 5; i++) add(1,1,0,1,0,0, 4-i,0,0,'h0A+i,1);
    for (int i = 0; i < 6; i++) add(1,1,1,0,0,'h10+i, i+1,0,0,'h0E,0);
    for (int i = 0; i < 6; i++) add(1,1,0,1,0,0, 5-i,0,0,'h10+i,1);
    for (int i = 0; i < 3; i++) add(1,1,1,0,0,'h30+i, i+1,0,0,'h15,0);
    add(1,1,1,1,0,'h33, 3,0,0,'h30,1);
    for (int i = 0; i < 5; i++) add(1,1,1,0,0,'h34+i, 4+i,0,0,'h30,0);
    add(1,1,1,1,0,'h99, 7,1,0,'h31,1);
    add(1,1,0,0,1,0, 7,0,0,'h31,0);
    add(1,1,0,1,0,0, 6,0,0,'h32,1);
    add(1,1,0,1,0,0, 5,0,0,'h33,1);
    add(1,0,1,1,1,'h77, 5,0,0,'h33,0);
    add(0,1,1,1,0,'h55, 0,0,0,0,0);
    add(1,1,1,0,0,'h66, 1,0,0,0,0);
    add(1,1,0,1,0,0, 0,0,0,'h66,1);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
      step();
      chk($sformatf("vec%0d.count", i), int'(count), tbl[i].cnt);
      chk($sformatf("vec%0d.full", i), int'(full), int'(tbl[i].cnt == DEPTH));
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(tbl[i].cnt == 0));
      chk($sformatf("vec%0d.afull", i), int'(almost_full), int'(tbl[i].cnt >= AF));
      chk($sformatf("vec%0d.aempty", i), int'(almost_empty), int'(tbl[i].cnt <= AE));
      chk($sformatf("vec%0d.ovf", i), int'(overflow), int'(tbl[i].ovf));
      chk($sformatf("vec%0d.udf", i), int'(underflow), int'(tbl[i].udf));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("vec%0d.dout", i), int'(dout), int'(tbl[i].dout));
      chk($sformatf("vec%0d.dv", i), int'(dout_valid), int'(tbl[i].dv));
`endif
    end

    // Corner sequences
    set_in(0,1,0,0,0,0); step();
    set_in(1,1,1,0,0,'hA5); step();
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft.first_dout", int'(dout), 'hA5);
    chk("fwft.first_dv", int'(dout_valid), 1);
    set_in(1,1,0,1,0,0); step();
    chk("fwft.pop_dv", int'(dout_valid), 0);
    chk("fwft.pop_empty", int'(empty), 1);
`else
    chk("std.no_fallthrough_dv", int'(dout_valid), 0);
    chk("std.no_fallthrough_dout", int'(dout), 0);
    set_in(1,1,0,1,0,0); step();
    chk("std.pop_dout", int'(dout), 'hA5);
    chk("std.pop_dv", int'(dout_valid), 1);
    set_in(1,1,0,0,0,0); step();
    chk("std.dv_one_cycle", int'(dout_valid), 0);
    chk("std.dout_hold", int'(dout), 'hA5);
`endif

    // Randomised traffic against the queue model
    set_in(0,1,0,0,0,0); step();
    check_vs_model("rnd_reset");
    for (int k = 0; k < 3000; k++) begin
      int wp;
      wp = ((k / 150) % 2 == 0) ? 75 : 30;
      set_in($urandom_range(0, 99) != 0,
             $urandom_range(0, 7) != 0,
             $urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < (100 - wp),
             $urandom_range(0, 15) == 0,
             DW'($urandom));
      step();
      check_vs_model($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
